// File: rtl/bus_addr_encoder.sv
// bus_addr_encoder: collects request pulses into sticky pending bits and serves them
// one at a time as a binary address with a valid/ready handshake. Requests that hit an
// already-pending slot are counted in a saturating drop counter.
// Optional build macro: BUS_ENC_ROUND_ROBIN_EN selects round-robin arbitration instead of
// fixed lowest-index-first priority.
module bus_addr_encoder #(
  parameter int N_REQ  = 8,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_REQ-1:0]  req_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [N_REQ-1:0]  pending_o,
  output logic [CNT_W-1:0]  drop_cnt_o
);

  localparam int SUM_W = CNT_W + ADDR_W + 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_t;

  state_t              state_q, state_d;
  logic [N_REQ-1:0]    pend_q, pend_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                valid_q, valid_d;
  logic [CNT_W-1:0]    drop_q, drop_d;

  logic                accept;
  logic [N_REQ-1:0]    clr;
  logic [N_REQ-1:0]    rem;
  logic [ADDR_W:0]     n_drop;

  // Number of set bits in a request vector; N_REQ <= 2**(ADDR_W-1) so ADDR_W+1 bits suffice.
  function automatic logic [ADDR_W:0] popcount(input logic [N_REQ-1:0] v);
    logic [ADDR_W:0] cnt;
    cnt = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cnt = cnt + {{ADDR_W{1'b0}}, v[i]};
    end
    return cnt;
  endfunction

  // Saturating add of the drop increment; the counter sticks at all-ones.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [ADDR_W:0]  b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({CNT_W{1'b1}})) begin
      return {CNT_W{1'b1}};
    end
    return s[CNT_W-1:0];
  endfunction

`ifdef BUS_ENC_ROUND_ROBIN_EN
  logic [ADDR_W-1:0] rr_q, rr_d;

  // Round-robin pick: first set bit at or after start, wrapping N_REQ-1 -> 0.
  function automatic logic [ADDR_W-1:0] sel(input logic [N_REQ-1:0]  v,
                                            input logic [ADDR_W-1:0] start);
    logic [ADDR_W-1:0] r;
    int                idx;
    r = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = (int'(start) + k) % N_REQ;
      if (v[idx]) r = ADDR_W'(idx);
    end
    return r;
  endfunction
`else
  // Fixed priority pick: lowest set index wins.
  function automatic logic [ADDR_W-1:0] sel(input logic [N_REQ-1:0] v);
    logic [ADDR_W-1:0] r;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (v[i]) r = ADDR_W'(i);
    end
    return r;
  endfunction
`endif

  // Handshake, pending-bit update and drop counting.
  always_comb begin
    accept = valid_q & ready_i;
    clr    = accept ? (N_REQ'(1) << addr_q) : '0;
    pend_d = (pend_q & ~clr) | req_i;
    rem    = pend_d & ~clr;
    n_drop = popcount(req_i & pend_q & ~clr);
    drop_d = sat_add(drop_q, n_drop);
  end

  // Next-state and address/valid selection; a new address is chosen only when loading.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    valid_d = valid_q;
`ifdef BUS_ENC_ROUND_ROBIN_EN
    rr_d    = rr_q;
    if (accept) begin
      rr_d = (addr_q == ADDR_W'(N_REQ - 1)) ? '0 : addr_q + 1'b1;
    end
`endif
    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (pend_q != '0) begin
`ifdef BUS_ENC_ROUND_ROBIN_EN
          addr_d = sel(pend_q, rr_q);
`else
          addr_d = sel(pend_q);
`endif
          valid_d = 1'b1;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (accept) begin
          if (rem != '0) begin
`ifdef BUS_ENC_ROUND_ROBIN_EN
            addr_d = sel(rem, rr_d);
`else
            addr_d = sel(rem);
`endif
            valid_d = 1'b1;
          end else begin
            valid_d = 1'b0;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset wins over any handshake in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      drop_q  <= drop_d;
    end
  end

`ifdef BUS_ENC_ROUND_ROBIN_EN
  // Round-robin search pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q <= '0;
    end else begin
      rr_q <= rr_d;
    end
  end
`endif

  assign addr_o     = addr_q;
  assign valid_o    = valid_q;
  assign pending_o  = pend_q;
  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_bus_addr_encoder.sv
// Directed testbench for bus_addr_encoder (default parameters, N_REQ=8, ADDR_W=4, CNT_W=8).
module tb_bus_addr_encoder;

  logic       clk;
  logic       rst;
  logic [7:0] req_i;
  logic [3:0] addr_o;
  logic       valid_o;
  logic       ready_i;
  logic [7:0] pending_o;
  logic [7:0] drop_cnt_o;

  int total;
  int bad;

  bus_addr_encoder #(
    .N_REQ (8),
    .ADDR_W(4),
    .CNT_W (8)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .addr_o    (addr_o),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .pending_o (pending_o),
    .drop_cnt_o(drop_cnt_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are examined 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic v, input logic [3:0] a,
                         input logic [7:0] p, input logic [7:0] d);
    chk({tag, ".valid"}, 32'(valid_o), 32'(v));
    chk({tag, ".addr"}, 32'(addr_o), 32'(a));
    chk({tag, ".pend"}, 32'(pending_o), 32'(p));
    chk({tag, ".drop"}, 32'(drop_cnt_o), 32'(d));
  endtask

  initial begin
    total   = 0;
    bad     = 0;
    rst     = 1'b0;
    req_i   = 8'h00;
    ready_i = 1'b0;
    #2;

    // T1 reset with all requests asserted
    rst = 1'b1; req_i = 8'hFF;
    tick();
    tick();
    chk_all("t1_inrst", 1'b0, 4'h0, 8'h00, 8'h00);
    rst = 1'b0; req_i = 8'h00;
    tick();
    chk_all("t1_after", 1'b0, 4'h0, 8'h00, 8'h00);

    // T2 single request on slot 2
    ready_i = 1'b1; req_i = 8'b0000_0100;
    tick();
    chk_all("t2_c1", 1'b0, 4'h0, 8'h04, 8'h00);
    req_i = 8'h00;
    tick();
    chk_all("t2_c2", 1'b1, 4'h2, 8'h04, 8'h00);
    tick();
    chk_all("t2_c3", 1'b0, 4'h2, 8'h00, 8'h00);

    // T3 burst on slots 0, 1, 7: lowest first, one per cycle
    req_i = 8'b1000_0011;
    tick();
    chk_all("t3_c1", 1'b0, 4'h2, 8'h83, 8'h00);
    req_i = 8'h00;
    tick();
    chk_all("t3_g0", 1'b1, 4'h0, 8'h83, 8'h00);
    tick();
    chk_all("t3_g1", 1'b1, 4'h1, 8'h82, 8'h00);
    tick();
    chk_all("t3_g7", 1'b1, 4'h7, 8'h80, 8'h00);
    tick();
    chk_all("t3_end", 1'b0, 4'h7, 8'h00, 8'h00);

    // T4 backpressure on slot 5 while slot 1 pulses twice (second pulse is a drop)
    ready_i = 1'b0; req_i = 8'b0010_0000;
    tick();
    req_i = 8'h00;
    tick();
    chk_all("t4_offer", 1'b1, 4'h5, 8'h20, 8'h00);
    for (int i = 0; i < 5; i++) begin
      req_i = (i == 0 || i == 2) ? 8'h02 : 8'h00;
      tick();
      chk("t4_hold.valid", 32'(valid_o), 32'd1);
      chk("t4_hold.addr", 32'(addr_o), 32'd5);
    end
    chk_all("t4_wait", 1'b1, 4'h5, 8'h22, 8'h01);
    req_i = 8'h00; ready_i = 1'b1;
    tick();
    chk_all("t4_next", 1'b1, 4'h1, 8'h02, 8'h01);
    tick();
    chk_all("t4_end", 1'b0, 4'h1, 8'h00, 8'h01);

    // T7 re-request of slot 2 on its own accept cycle is kept, not dropped
    req_i = 8'h04;
    tick();
    req_i = 8'h00;
    tick();
    chk_all("t7_offer", 1'b1, 4'h2, 8'h04, 8'h01);
    req_i = 8'h04;
    tick();
    chk_all("t7_acc", 1'b0, 4'h2, 8'h04, 8'h01);
    req_i = 8'h00;
    tick();
    chk_all("t7_reoffer", 1'b1, 4'h2, 8'h04, 8'h01);
    tick();
    chk_all("t7_end", 1'b0, 4'h2, 8'h00, 8'h01);

    // T5 drop counter saturation on slot 3 held unserved
    rst = 1'b1;
    tick();
    rst = 1'b0; ready_i = 1'b0; req_i = 8'h08;
    tick();
    req_i = 8'h00;
    tick();
    chk_all("t5_offer", 1'b1, 4'h3, 8'h08, 8'h00);
    req_i = 8'h08;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (i == 253) chk("t5_fe", 32'(drop_cnt_o), 32'hFE);
      if (i == 254) chk("t5_ff", 32'(drop_cnt_o), 32'hFF);
    end
    req_i = 8'h00;
    chk_all("t5_sat", 1'b1, 4'h3, 8'h08, 8'hFF);

    // T6 reset while offering with ready high: no accept, all cleared
    rst = 1'b1; ready_i = 1'b1;
    tick();
    chk_all("t6_rst", 1'b0, 4'h0, 8'h00, 8'h00);
    rst = 1'b0;
    tick();
    chk_all("t6_after", 1'b0, 4'h0, 8'h00, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
